// File: rtl/ct_idu_vreg_alloc_pkg.sv
// Shared types and helpers for the IR-stage free-vreg allocation buffer.
package ct_idu_vreg_alloc_pkg;

    localparam int PREG_W_DEF = 6;
    localparam int DEPTH_DEF  = 8;

    typedef logic [1:0]          lane_idx_t;
    typedef lane_idx_t [3:0]     lane_idx_vec_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/ct_idu_ir_vreg_alloc_buf_if.sv
// RTU offer/ack handshake and IR rename request/grant bundle for the vreg allocation buffer.
interface ct_idu_ir_vreg_alloc_buf_if #(
    parameter int PREG_W = 6
);
    logic [PREG_W-1:0] rtu_idu_alloc_xreg0;
    logic [PREG_W-1:0] rtu_idu_alloc_xreg1;
    logic [PREG_W-1:0] rtu_idu_alloc_xreg2;
    logic [PREG_W-1:0] rtu_idu_alloc_xreg3;
    logic              rtu_idu_alloc_xreg0_vld;
    logic              rtu_idu_alloc_xreg1_vld;
    logic              rtu_idu_alloc_xreg2_vld;
    logic              rtu_idu_alloc_xreg3_vld;
    logic              idu_rtu_ir_xreg0_alloc_vld;
    logic              idu_rtu_ir_xreg1_alloc_vld;
    logic              idu_rtu_ir_xreg2_alloc_vld;
    logic              idu_rtu_ir_xreg3_alloc_vld;
    logic              idu_rtu_ir_xreg_alloc_gateclk_vld;
    logic              ir_inst0_dst_req;
    logic              ir_inst1_dst_req;
    logic              ir_inst2_dst_req;
    logic              ir_inst3_dst_req;
    logic [PREG_W-1:0] ir_inst0_dst_preg;
    logic [PREG_W-1:0] ir_inst1_dst_preg;
    logic [PREG_W-1:0] ir_inst2_dst_preg;
    logic [PREG_W-1:0] ir_inst3_dst_preg;
    logic              ir_inst0_dst_preg_vld;
    logic              ir_inst1_dst_preg_vld;
    logic              ir_inst2_dst_preg_vld;
    logic              ir_inst3_dst_preg_vld;
    logic              ir_vreg_alloc_stall;

    // Offer/request side (RTU and IR rename)
    modport master (
        output rtu_idu_alloc_xreg0, rtu_idu_alloc_xreg1, rtu_idu_alloc_xreg2, rtu_idu_alloc_xreg3,
        output rtu_idu_alloc_xreg0_vld, rtu_idu_alloc_xreg1_vld,
        output rtu_idu_alloc_xreg2_vld, rtu_idu_alloc_xreg3_vld,
        output ir_inst0_dst_req, ir_inst1_dst_req, ir_inst2_dst_req, ir_inst3_dst_req,
        input  idu_rtu_ir_xreg0_alloc_vld, idu_rtu_ir_xreg1_alloc_vld,
        input  idu_rtu_ir_xreg2_alloc_vld, idu_rtu_ir_xreg3_alloc_vld,
        input  idu_rtu_ir_xreg_alloc_gateclk_vld,
        input  ir_inst0_dst_preg, ir_inst1_dst_preg, ir_inst2_dst_preg, ir_inst3_dst_preg,
        input  ir_inst0_dst_preg_vld, ir_inst1_dst_preg_vld,
        input  ir_inst2_dst_preg_vld, ir_inst3_dst_preg_vld,
        input  ir_vreg_alloc_stall
    );

    // Buffer side
    modport slave (
        input  rtu_idu_alloc_xreg0, rtu_idu_alloc_xreg1, rtu_idu_alloc_xreg2, rtu_idu_alloc_xreg3,
        input  rtu_idu_alloc_xreg0_vld, rtu_idu_alloc_xreg1_vld,
        input  rtu_idu_alloc_xreg2_vld, rtu_idu_alloc_xreg3_vld,
        input  ir_inst0_dst_req, ir_inst1_dst_req, ir_inst2_dst_req, ir_inst3_dst_req,
        output idu_rtu_ir_xreg0_alloc_vld, idu_rtu_ir_xreg1_alloc_vld,
        output idu_rtu_ir_xreg2_alloc_vld, idu_rtu_ir_xreg3_alloc_vld,
        output idu_rtu_ir_xreg_alloc_gateclk_vld,
        output ir_inst0_dst_preg, ir_inst1_dst_preg, ir_inst2_dst_preg, ir_inst3_dst_preg,
        output ir_inst0_dst_preg_vld, ir_inst1_dst_preg_vld,
        output ir_inst2_dst_preg_vld, ir_inst3_dst_preg_vld,
        output ir_vreg_alloc_stall
    );

endinterface

// File: rtl/ct_idu_vreg_alloc_compact.sv
// 4-lane valid compaction: slot offset of each lane among valid lanes, plus valid count.
module ct_idu_vreg_alloc_compact
    import ct_idu_vreg_alloc_pkg::*;
(
    input  logic [3:0]    vld_i,
    output lane_idx_vec_t off_o,
    output logic [2:0]    cnt_o
);

    logic [2:0] acc;

    always_comb begin
        acc   = 3'd0;
        off_o = '0;
        for (int i = 0; i < 4; i++) begin
            off_o[i] = acc[1:0];
            acc      = acc + {2'b00, vld_i[i]};
        end
        cnt_o = acc;
    end

endmodule

// File: rtl/ct_idu_ir_vreg_alloc_buf.sv
// IR-stage free-vreg FIFO: takes RTU offers all-or-none, grants in-order groups to inst0..3.
// Optional same-cycle bypass on an empty buffer: define CT_IDU_VREG_ALLOC_BYPASS_EN.
module ct_idu_ir_vreg_alloc_buf
    import ct_idu_vreg_alloc_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int PREG_W = PREG_W_DEF,
    parameter int CNT_W  = 4
) (
    input  logic                             forever_cpuclk,
    input  logic                             cpurst,
    ct_idu_ir_vreg_alloc_buf_if.slave        bus,
    output logic [CNT_W-1:0]                 buf_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PREG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [PREG_W-1:0] offer   [4];
    logic [PREG_W-1:0] dst     [4];
    logic [3:0]        vld, req, ack, pvld;
    lane_idx_vec_t     off;
    logic [2:0]        offer_cnt, req_cnt, byp_cnt, push_cnt, pop_cnt;
    logic              room_ok, accept, grant_fifo, byp, stall;

    assign offer[0] = bus.rtu_idu_alloc_xreg0;
    assign offer[1] = bus.rtu_idu_alloc_xreg1;
    assign offer[2] = bus.rtu_idu_alloc_xreg2;
    assign offer[3] = bus.rtu_idu_alloc_xreg3;
    assign vld = {bus.rtu_idu_alloc_xreg3_vld, bus.rtu_idu_alloc_xreg2_vld,
                  bus.rtu_idu_alloc_xreg1_vld, bus.rtu_idu_alloc_xreg0_vld};
    assign req = {bus.ir_inst3_dst_req, bus.ir_inst2_dst_req,
                  bus.ir_inst1_dst_req, bus.ir_inst0_dst_req};

    ct_idu_vreg_alloc_compact u_compact (
        .vld_i (vld),
        .off_o (off),
        .cnt_o (offer_cnt)
    );

    assign req_cnt = popcount4(req);

    // Room is judged on the registered count only; a same-cycle pop never makes room.
    assign room_ok    = (int'(DEPTH) - int'(cnt_q)) >= 4;
    assign accept     = !cpurst && room_ok;
    assign grant_fifo = !cpurst && (req_cnt != 3'd0) && (CNT_W'(req_cnt) <= cnt_q);

`ifdef CT_IDU_VREG_ALLOC_BYPASS_EN
    assign byp = accept && (cnt_q == '0) && (req_cnt != 3'd0) && (offer_cnt >= req_cnt);
`else
    assign byp = 1'b0;
`endif

    assign ack      = accept ? vld : 4'b0000;
    assign byp_cnt  = byp ? req_cnt : 3'd0;
    assign push_cnt = accept ? (offer_cnt - byp_cnt) : 3'd0;
    assign pop_cnt  = grant_fifo ? req_cnt : 3'd0;
    assign pvld     = (grant_fifo || byp) ? req : 4'b0000;
    assign stall    = (req_cnt != 3'd0) && !grant_fifo && !byp;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            dst[k] = mem_q[rptr_q + PTR_W'(k)];
`ifdef CT_IDU_VREG_ALLOC_BYPASS_EN
            if (byp) begin
                for (int i = 0; i < 4; i++) begin
                    if (vld[i] && (off[i] == 2'(k))) dst[k] = offer[i];
                end
            end
`endif
        end
    end

    assign wptr_d = wptr_q + PTR_W'(push_cnt);
    assign rptr_d = rptr_q + PTR_W'(pop_cnt);
    assign cnt_d  = cnt_q + CNT_W'(push_cnt) - CNT_W'(pop_cnt);

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entries are data only; bypassed lanes occupy the lowest compacted slots and are skipped.
    always_ff @(posedge forever_cpuclk) begin
        for (int i = 0; i < 4; i++) begin
            if (ack[i] && ({1'b0, off[i]} >= byp_cnt)) begin
                mem_q[wptr_q + PTR_W'(off[i]) - PTR_W'(byp_cnt)] <= offer[i];
            end
        end
    end

    assign bus.idu_rtu_ir_xreg0_alloc_vld        = ack[0];
    assign bus.idu_rtu_ir_xreg1_alloc_vld        = ack[1];
    assign bus.idu_rtu_ir_xreg2_alloc_vld        = ack[2];
    assign bus.idu_rtu_ir_xreg3_alloc_vld        = ack[3];
    assign bus.idu_rtu_ir_xreg_alloc_gateclk_vld = |ack;
    assign bus.ir_inst0_dst_preg                 = dst[0];
    assign bus.ir_inst1_dst_preg                 = dst[1];
    assign bus.ir_inst2_dst_preg                 = dst[2];
    assign bus.ir_inst3_dst_preg                 = dst[3];
    assign bus.ir_inst0_dst_preg_vld             = pvld[0];
    assign bus.ir_inst1_dst_preg_vld             = pvld[1];
    assign bus.ir_inst2_dst_preg_vld             = pvld[2];
    assign bus.ir_inst3_dst_preg_vld             = pvld[3];
    assign bus.ir_vreg_alloc_stall               = stall;
    assign buf_cnt                               = cnt_q;

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst) begin
            assert (cnt_q <= CNT_W'(DEPTH));
            assert (req inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111});
            assert ((ack & ~vld) == 4'b0000);
        end
    end

endmodule

// File: tb/tb_ct_idu_ir_vreg_alloc_buf.sv
// Randomized bench for ct_idu_ir_vreg_alloc_buf against a queue-based model, plus directed literal checks.
module tb_ct_idu_ir_vreg_alloc_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] buf_cnt;
    int         n_chk  = 0;
    int         n_pass = 0;

    ct_idu_ir_vreg_alloc_buf_if #(.PREG_W(6)) bus ();

    ct_idu_ir_vreg_alloc_buf dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .bus            (bus),
        .buf_cnt        (buf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [3:0] get_vld();
        return {bus.rtu_idu_alloc_xreg3_vld, bus.rtu_idu_alloc_xreg2_vld,
                bus.rtu_idu_alloc_xreg1_vld, bus.rtu_idu_alloc_xreg0_vld};
    endfunction
    function automatic logic [3:0] get_req();
        return {bus.ir_inst3_dst_req, bus.ir_inst2_dst_req, bus.ir_inst1_dst_req, bus.ir_inst0_dst_req};
    endfunction
    function automatic logic [3:0] get_ack();
        return {bus.idu_rtu_ir_xreg3_alloc_vld, bus.idu_rtu_ir_xreg2_alloc_vld,
                bus.idu_rtu_ir_xreg1_alloc_vld, bus.idu_rtu_ir_xreg0_alloc_vld};
    endfunction
    function automatic logic [3:0] get_pvld();
        return {bus.ir_inst3_dst_preg_vld, bus.ir_inst2_dst_preg_vld,
                bus.ir_inst1_dst_preg_vld, bus.ir_inst0_dst_preg_vld};
    endfunction
    function automatic int get_offer(input int k);
        case (k)
            0: return int'(bus.rtu_idu_alloc_xreg0);
            1: return int'(bus.rtu_idu_alloc_xreg1);
            2: return int'(bus.rtu_idu_alloc_xreg2);
            default: return int'(bus.rtu_idu_alloc_xreg3);
        endcase
    endfunction
    function automatic int get_dst(input int k);
        case (k)
            0: return int'(bus.ir_inst0_dst_preg);
            1: return int'(bus.ir_inst1_dst_preg);
            2: return int'(bus.ir_inst2_dst_preg);
            default: return int'(bus.ir_inst3_dst_preg);
        endcase
    endfunction

    // Reference model: the buffer is just an ordered list of free registers.
    int   q[$];
    bit   mvalid = 1'b0;
    int   offers[$];
    int   grants[$];
    logic [3:0] m_vld, m_req, m_ack, m_pvld;
    int   oc, rc;
    bit   accept, byp, m_stall;

    always @(negedge clk) begin
        m_vld = get_vld();
        m_req = get_req();
        offers.delete();
        for (int i = 0; i < 4; i++) if (m_vld[i]) offers.push_back(get_offer(i));
        oc = offers.size();
        rc = 0;
        for (int i = 0; i < 4; i++) rc += int'(m_req[i]);
        if (rst) begin
            chk("rst_ack", int'(get_ack()), 0);
            chk("rst_gateclk", int'(bus.idu_rtu_ir_xreg_alloc_gateclk_vld), 0);
            chk("rst_pvld", int'(get_pvld()), 0);
            chk("rst_stall", int'(bus.ir_vreg_alloc_stall), int'(|m_req));
            q.delete();
            mvalid = 1'b1;
        end else if (mvalid) begin
            chk("buf_cnt", int'(buf_cnt), q.size());
            accept = (8 - q.size()) >= 4;
            byp = 1'b0;
`ifdef CT_IDU_VREG_ALLOC_BYPASS_EN
            byp = (q.size() == 0) && (rc > 0) && (oc >= rc);
`endif
            m_ack = accept ? m_vld : 4'b0000;
            grants.delete();
            if (byp) begin
                for (int k = 0; k < rc; k++) grants.push_back(offers[k]);
            end else if (rc > 0 && rc <= q.size()) begin
                for (int k = 0; k < rc; k++) grants.push_back(q.pop_front());
            end
            m_stall = (rc > 0) && (grants.size() == 0);
            m_pvld  = (grants.size() > 0) ? m_req : 4'b0000;
            chk("ack", int'(get_ack()), int'(m_ack));
            chk("gateclk", int'(bus.idu_rtu_ir_xreg_alloc_gateclk_vld), int'(|m_ack));
            chk("stall", int'(bus.ir_vreg_alloc_stall), int'(m_stall));
            chk("preg_vld", int'(get_pvld()), int'(m_pvld));
            for (int k = 0; k < 4; k++) if (m_pvld[k]) chk($sformatf("dst_preg%0d", k), get_dst(k), grants[k]);
            if (accept) for (int j = (byp ? rc : 0); j < oc; j++) q.push_back(offers[j]);
        end
    end

    task automatic apply(input int a, input int b, input int c, input int d,
                         input logic [3:0] v, input logic [3:0] r, input logic rs);
        bus.rtu_idu_alloc_xreg0     = 6'(a);
        bus.rtu_idu_alloc_xreg1     = 6'(b);
        bus.rtu_idu_alloc_xreg2     = 6'(c);
        bus.rtu_idu_alloc_xreg3     = 6'(d);
        bus.rtu_idu_alloc_xreg0_vld = v[0];
        bus.rtu_idu_alloc_xreg1_vld = v[1];
        bus.rtu_idu_alloc_xreg2_vld = v[2];
        bus.rtu_idu_alloc_xreg3_vld = v[3];
        bus.ir_inst0_dst_req        = r[0];
        bus.ir_inst1_dst_req        = r[1];
        bus.ir_inst2_dst_req        = r[2];
        bus.ir_inst3_dst_req        = r[3];
        rst                         = rs;
    endtask

    // Drive a cycle's inputs just after the edge, then park mid-cycle for literal checks.
    task automatic step(input int a, input int b, input int c, input int d,
                        input logic [3:0] v, input logic [3:0] r, input logic rs);
        @(posedge clk);
        #1;
        apply(a, b, c, d, v, r, rs);
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rv, rr;
        int         tl;
        apply(0, 0, 0, 0, 4'b0000, 4'b0000, 1'b1);

        step(0, 0, 0, 0, 4'b0000, 4'b0001, 1'b1);
        chk("L_rst_stall", int'(bus.ir_vreg_alloc_stall), 1);
        step(1, 2, 3, 4, 4'b1111, 4'b0000, 1'b1);
        chk("L_rst_ack", int'(get_ack()), 0);

        step(5, 9, 12, 33, 4'b1111, 4'b0000, 1'b0);
        chk("L_cnt0", int'(buf_cnt), 0);
        chk("L_ack_all", int'(get_ack()), 15);
        step(0, 0, 0, 0, 4'b0000, 4'b1111, 1'b0);
        chk("L_cnt4", int'(buf_cnt), 4);
        chk("L_dst0", get_dst(0), 5);
        chk("L_dst1", get_dst(1), 9);
        chk("L_dst2", get_dst(2), 12);
        chk("L_dst3", get_dst(3), 33);
        chk("L_pvld4", int'(get_pvld()), 15);

        step(0, 7, 0, 8, 4'b1010, 4'b0000, 1'b0);
        chk("L_cnt_drained", int'(buf_cnt), 0);
        chk("L_ack_1010", int'(get_ack()), 10);
        step(0, 0, 0, 0, 4'b0000, 4'b0011, 1'b0);
        chk("L_cmp_dst0", get_dst(0), 7);
        chk("L_cmp_dst1", get_dst(1), 8);

        step(1, 2, 3, 4, 4'b1111, 4'b0000, 1'b0);
        step(6, 0, 0, 0, 4'b0001, 4'b0000, 1'b0);
        step(10, 11, 12, 13, 4'b1111, 4'b0000, 1'b0);
        chk("L_full_cnt5", int'(buf_cnt), 5);
        chk("L_full_ack", int'(get_ack()), 0);
        step(0, 0, 0, 0, 4'b0000, 4'b0001, 1'b0);
        chk("L_full_hold", int'(buf_cnt), 5);
        chk("L_pop1_dst", get_dst(0), 1);
        step(20, 21, 22, 23, 4'b1111, 4'b0111, 1'b0);
        chk("L_cnt4b", int'(buf_cnt), 4);
        chk("L_pushpop_ack", int'(get_ack()), 15);
        chk("L_pushpop_dst2", get_dst(2), 4);
        step(0, 0, 0, 0, 4'b0000, 4'b0111, 1'b0);
        chk("L_cnt5_next", int'(buf_cnt), 5);
        chk("L_pop3_dst0", get_dst(0), 6);
        step(0, 0, 0, 0, 4'b0000, 4'b0111, 1'b0);
        chk("L_cnt2", int'(buf_cnt), 2);
        chk("L_short_stall", int'(bus.ir_vreg_alloc_stall), 1);
        chk("L_short_pvld", int'(get_pvld()), 0);
        step(0, 0, 0, 0, 4'b0000, 4'b0011, 1'b0);
        chk("L_cnt2_hold", int'(buf_cnt), 2);
        chk("L_grant2_stall", int'(bus.ir_vreg_alloc_stall), 0);
        chk("L_grant2_dst0", get_dst(0), 22);
        chk("L_grant2_dst1", get_dst(1), 23);

        step(40, 41, 42, 0, 4'b0111, 4'b0011, 1'b0);
        chk("L_empty_ack", int'(get_ack()), 7);
`ifdef CT_IDU_VREG_ALLOC_BYPASS_EN
        chk("L_byp_stall", int'(bus.ir_vreg_alloc_stall), 0);
        chk("L_byp_dst0", get_dst(0), 40);
        chk("L_byp_dst1", get_dst(1), 41);
        step(0, 0, 0, 0, 4'b0000, 4'b0000, 1'b0);
        chk("L_byp_cnt1", int'(buf_cnt), 1);
`else
        chk("L_empty_stall", int'(bus.ir_vreg_alloc_stall), 1);
        step(0, 0, 0, 0, 4'b0000, 4'b0000, 1'b0);
        chk("L_empty_cnt3", int'(buf_cnt), 3);
`endif

        step(0, 0, 0, 0, 4'b0000, 4'b0000, 1'b1);
        step(30, 31, 32, 33, 4'b1111, 4'b0000, 1'b0);
        step(34, 35, 0, 0, 4'b0011, 4'b0000, 1'b0);
        step(50, 51, 52, 53, 4'b1111, 4'b0000, 1'b1);
        chk("L_rst_cnt6", int'(buf_cnt), 6);
        chk("L_rst_pending_ack", int'(get_ack()), 0);
        step(0, 0, 0, 0, 4'b0000, 4'b0001, 1'b0);
        chk("L_after_rst_cnt", int'(buf_cnt), 0);
        chk("L_after_rst_stall", int'(bus.ir_vreg_alloc_stall), 1);

        // Random traffic alternating fill-biased and drain-biased phases to wrap pointers.
        for (int n = 0; n < 3000; n++) begin
            rv = 4'($urandom_range(0, 15));
            tl = $urandom_range(0, 4);
            if (((n / 25) % 2) == 0 && $urandom_range(0, 2) != 0) tl = 0;
            if (((n / 25) % 2) == 1 && $urandom_range(0, 2) != 0) rv = 4'b0000;
            rr = 4'((1 << tl) - 1);
            step($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
                 $urandom_range(0, 63), rv, rr, ($urandom_range(0, 199) == 0));
        end
        step(0, 0, 0, 0, 4'b0000, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
